// File: rtl/run_sequencer.sv
// Run sequencer for the NanoMIPS core: holds the core in reset, releases it, gates execution,
// counts executed cycles and enforces a watchdog. Optional single-step gating: RUN_SEQUENCER_STEP_EN.
module run_sequencer #(
  parameter int unsigned CW           = 16,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          core_done,
`ifdef RUN_SEQUENCER_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  output logic          core_reset,
  output logic          core_run,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_CYCLES - 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(RESET_CYCLES - 1);

  state_t        state;
  logic [7:0]    hold_cnt;
  logic [CW-1:0] count_next;
  logic          step_on;
  logic          step_rise;

  assign count_next = cycle_count + CW'(1);

`ifdef RUN_SEQUENCER_STEP_EN
  logic step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_on   = step_mode;
  assign step_rise = step & ~step_q;
`else
  assign step_on   = 1'b0;
  assign step_rise = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      core_run    <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      // Every executed cycle is counted, even one that is aborted or ends the run.
      if (core_run) cycle_count <= count_next;

      if (abort) begin
        state      <= IDLE;
        core_reset <= 1'b1;
        core_run   <= 1'b0;
        busy       <= 1'b0;
        finished   <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state       <= HOLD;
              hold_cnt    <= '0;
              cycle_count <= '0;
              core_reset  <= 1'b1;
              core_run    <= 1'b0;
              busy        <= 1'b1;
              finished    <= 1'b0;
              timeout     <= 1'b0;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= RUN;
              core_reset <= 1'b0;
              core_run   <= ~step_on;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          RUN: begin
            if (core_run && core_done) begin
              state    <= DONE;
              core_run <= 1'b0;
              busy     <= 1'b0;
              finished <= 1'b1;
              timeout  <= 1'b0;
            end else if (core_run && cycle_count == LAST_COUNT) begin
              state    <= DONE;
              core_run <= 1'b0;
              busy     <= 1'b0;
              finished <= 1'b1;
              timeout  <= 1'b1;
            end else begin
              core_run <= ~step_on | step_rise;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: phase-level reference model checked every cycle, plus literal checkpoints.
module tb_run_sequencer;

  localparam int RC   = 2;
  localparam int MAXC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        core_done = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        core_reset, core_run, busy, finished, timeout;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_sequencer #(.CW(16), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .core_done(core_done),
`ifdef RUN_SEQUENCER_STEP_EN
    .step_mode(step_mode),
    .step(step),
`endif
    .core_reset(core_reset),
    .core_run(core_run),
    .busy(busy),
    .finished(finished),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the run is described by its phase; reset/busy follow from the phase.
  typedef enum int {M_IDLE, M_HOLD, M_RUN, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  int   m_hold_left = 0;
  int   m_cnt = 0;
  bit   m_fin = 0, m_to = 0, m_run = 0, m_stepq = 0;
  bit   m_exec, m_rise;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = M_IDLE; m_cnt = 0; m_fin = 0; m_to = 0; m_run = 0; m_stepq = 0; m_hold_left = 0;
    end else begin
      m_exec  = m_run;
      m_rise  = step && !m_stepq;
      m_stepq = step;
      if (m_exec) m_cnt++;
      if (abort) begin
        m_ph = M_IDLE; m_fin = 0; m_to = 0; m_run = 0;
      end else if ((m_ph == M_IDLE || m_ph == M_DONE) && start) begin
        m_ph = M_HOLD; m_hold_left = RC; m_cnt = 0; m_fin = 0; m_to = 0; m_run = 0;
      end else if (m_ph == M_HOLD) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_ph  = M_RUN;
          m_run = !step_mode;
        end
      end else if (m_ph == M_RUN) begin
        if (m_exec && (core_done || m_cnt == MAXC)) begin
          m_ph = M_DONE; m_fin = 1; m_to = !core_done; m_run = 0;
        end else begin
          m_run = !step_mode || m_rise;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("core_reset", int'(core_reset), int'(m_ph == M_IDLE || m_ph == M_HOLD));
    check("busy", int'(busy), int'(m_ph == M_HOLD || m_ph == M_RUN));
    check("core_run", int'(core_run), int'(m_run));
    check("finished", int'(finished), int'(m_fin));
    check("timeout", int'(timeout), int'(m_to));
    check("cycle_count", int'(cycle_count), m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RC) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_core_run", int'(core_run), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_count", int'(cycle_count), 0);
    reset = 1'b0;
    tick();

    // Normal run, done on the 10th executed cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_hold1_reset", int'(core_reset), 1);
    check("t1_hold1_busy", int'(busy), 1);
    check("t1_hold1_run", int'(core_run), 0);
    tick();
    check("t1_hold2_reset", int'(core_reset), 1);
    check("t1_hold2_run", int'(core_run), 0);
    tick();
    check("t1_run1_run", int'(core_run), 1);
    check("t1_run1_reset", int'(core_reset), 0);
    check("t1_run1_count", int'(cycle_count), 0);
    repeat (9) tick();
    check("t1_run10_count", int'(cycle_count), 9);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("t1_fin", int'(finished), 1);
    check("t1_count", int'(cycle_count), 10);
    check("t1_timeout", int'(timeout), 0);
    check("t1_run", int'(core_run), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_done_reset", int'(core_reset), 0);
    repeat (3) tick();
    check("t1_held_count", int'(cycle_count), 10);
    check("t1_held_fin", int'(finished), 1);

    // Restart from DONE, then watchdog expiry
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_restart_count", int'(cycle_count), 0);
    check("t2_restart_busy", int'(busy), 1);
    check("t2_restart_reset", int'(core_reset), 1);
    check("t2_restart_fin", int'(finished), 0);
    repeat (RC) tick();
    repeat (19) tick();
    check("t2_run20_count", int'(cycle_count), 19);
    check("t2_run20_run", int'(core_run), 1);
    tick();
    check("t2_timeout", int'(timeout), 1);
    check("t2_fin", int'(finished), 1);
    check("t2_count", int'(cycle_count), 20);
    check("t2_run", int'(core_run), 0);
    repeat (2) tick();
    check("t2_held_count", int'(cycle_count), 20);

    // Done on exactly the watchdog cycle; a start while busy is ignored
    begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    check("t3_run20_count", int'(cycle_count), 19);
    check("t3_run20_busy", int'(busy), 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("t3_fin", int'(finished), 1);
    check("t3_timeout", int'(timeout), 0);
    check("t3_count", int'(cycle_count), 20);

    // Abort beats done on the 5th executed cycle
    begin_run();
    repeat (4) tick();
    abort = 1'b1;
    core_done = 1'b1;
    tick();
    abort = 1'b0;
    core_done = 1'b0;
    check("t4_reset", int'(core_reset), 1);
    check("t4_fin", int'(finished), 0);
    check("t4_count", int'(cycle_count), 5);
    check("t4_busy", int'(busy), 0);
    check("t4_run", int'(core_run), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t4_sa_busy", int'(busy), 0);
    check("t4_sa_count", int'(cycle_count), 5);

    // Asynchronous reset between edges mid-run
    begin_run();
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check("t5_reset", int'(core_reset), 1);
    check("t5_run", int'(core_run), 0);
    check("t5_count", int'(cycle_count), 0);
    check("t5_busy", int'(busy), 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef RUN_SEQUENCER_STEP_EN
    begin
      int pulses = 0;
      step_mode = 1'b1;
      begin_run();
      check("t6_enter_run", int'(core_run), 0);
      for (int p = 0; p < 3; p++) begin
        step = 1'b1;
        tick();
        pulses += int'(core_run);
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          pulses += int'(core_run);
          if (p == 1 && k == 0) core_done = 1'b1;
        end
        if (p == 1) begin
          check("t6_done_ignored_count", int'(cycle_count), 2);
          check("t6_done_ignored_fin", int'(finished), 0);
        end
      end
      core_done = 1'b0;
      step_mode = 1'b0;
      check("t6_pulses", pulses, 3);
      check("t6_count", int'(cycle_count), 3);
      check("t6_fin", int'(finished), 1);
      check("t6_timeout", int'(timeout), 0);
    end
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
